io_channel_ctrl: RTL and testbench

- Board-side I/O controller between physical switches/button/display and the processor's 4-channel I/O ports (dev_in/enter_in, dev_out/enter_out).
- Input side: debounces the enter button and captures the 32-bit switch word into the selected input channel. Holds that channel valid until the processor acknowledges consumption.
- Output side: latches each processor output strobe into a per-channel register. A selected register drives the display.

---
 rtl/io_channel_ctrl.sv | 168 ++++++++++++++++
 tb/tb_io_channel_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_channel_ctrl.sv
// Board-side I/O channel controller: debounced enter button loads the switch word into
// one of four processor input channels; processor output strobes latch into display registers.
module io_channel_ctrl #(
    parameter int DEB_CNT = 50000,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  sw_in,
    input  logic         btn_enter,
    input  logic [1:0]   ch_sel,
    output logic [127:0] dev_in,
    output logic [3:0]   enter_in,
    input  logic         in_ack,
    input  logic [1:0]   in_ack_ch,
    output logic [3:0]   overrun,
    input  logic         ovr_clr,
    input  logic [127:0] dev_out,
    input  logic [3:0]   enter_out,
    input  logic [1:0]   disp_sel,
    output logic [31:0]  disp_data,
    output logic [3:0]   out_valid
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    logic             r_btn_meta;
    logic             r_btn_s;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      r_dev_in [4];
    logic [3:0]       r_enter_in;
    logic [3:0]       r_overrun;

    logic [3:0]       r_eo_prev;
    logic [31:0]      r_out_reg [4];
    logic [3:0]       r_out_valid;

    logic             w_press_evt;
    logic [3:0]       w_ack;
    logic [3:0]       w_load;
    logic [3:0]       w_ovr_set;
    logic [3:0]       w_rise;
    logic [31:0]      w_dev_out [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_btn_meta <= btn_enter;
            r_btn_s    <= r_btn_meta;
        end
    end

    // The press event is decoded from the final qualifying cycle of WAIT_HIGH so the
    // load lands in the same edge that moves the FSM to IDLE_HIGH.
    assign w_press_evt = (r_state == WAIT_HIGH) && r_btn_s && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE_LOW: begin
                    if (r_btn_s) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!r_btn_s)
                        r_state <= IDLE_LOW;
                    else if (r_cnt == CNT_LAST)
                        r_state <= IDLE_HIGH;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                IDLE_HIGH: begin
                    if (!r_btn_s) begin
                        r_state <= WAIT_LOW;
                        r_cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (r_btn_s)
                        r_state <= IDLE_HIGH;
                    else if (r_cnt == CNT_LAST)
                        r_state <= IDLE_LOW;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE_LOW;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic w_press;
            assign w_press         = w_press_evt && (ch_sel == 2'(gi));
            assign w_ack[gi]       = in_ack && (in_ack_ch == 2'(gi));
            // An ack in the same cycle frees the channel first, so the press still loads.
            assign w_load[gi]      = w_press && (!r_enter_in[gi] || w_ack[gi]);
            assign w_ovr_set[gi]   = w_press && r_enter_in[gi] && !w_ack[gi];
            assign dev_in[gi*32 +: 32] = r_dev_in[gi];
            assign w_dev_out[gi]   = dev_out[gi*32 +: 32];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_dev_in[i] <= '0;
            end
            r_enter_in <= '0;
            r_overrun  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_load[i]) begin
                    r_dev_in[i]   <= sw_in;
                    r_enter_in[i] <= 1'b1;
                end else if (w_ack[i]) begin
                    r_enter_in[i] <= 1'b0;
                end
                if (w_ovr_set[i])
                    r_overrun[i] <= 1'b1;
                else if (ovr_clr)
                    r_overrun[i] <= 1'b0;
            end
        end
    end

    assign enter_in = r_enter_in;
    assign overrun  = r_overrun;

    assign w_rise = enter_out & ~r_eo_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eo_prev   <= '0;
            r_out_valid <= '0;
            for (int i = 0; i < 4; i++) begin
                r_out_reg[i] <= '0;
            end
        end else begin
            r_eo_prev   <= enter_out;
            r_out_valid <= r_out_valid | w_rise;
            for (int i = 0; i < 4; i++) begin
                if (w_rise[i])
                    r_out_reg[i] <= w_dev_out[i];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign disp_data = r_out_reg[disp_sel];

endmodule

// File: tb/tb_io_channel_ctrl.sv
// Scoreboard bench for io_channel_ctrl: a cycle-level reference model queues expected
// outputs per cycle; a negedge monitor pops and compares them against the DUT.
module tb_io_channel_ctrl;

    localparam int DEB_CNT = 4;
    localparam int CNT_W   = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  sw_in = '0;
    logic         btn_enter = 1'b0;
    logic [1:0]   ch_sel = '0;
    logic [127:0] dev_in;
    logic [3:0]   enter_in;
    logic         in_ack = 1'b0;
    logic [1:0]   in_ack_ch = '0;
    logic [3:0]   overrun;
    logic         ovr_clr = 1'b0;
    logic [127:0] dev_out = '0;
    logic [3:0]   enter_out = '0;
    logic [1:0]   disp_sel = '0;
    logic [31:0]  disp_data;
    logic [3:0]   out_valid;

    io_channel_ctrl #(.DEB_CNT(DEB_CNT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_enter(btn_enter),
        .ch_sel(ch_sel), .dev_in(dev_in), .enter_in(enter_in), .in_ack(in_ack),
        .in_ack_ch(in_ack_ch), .overrun(overrun), .ovr_clr(ovr_clr),
        .dev_out(dev_out), .enter_out(enter_out), .disp_sel(disp_sel),
        .disp_data(disp_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // staged stimulus, applied just after the next rising edge
    logic         s_btn = 1'b0;
    logic [31:0]  s_sw = '0;
    logic [1:0]   s_ch = '0;
    logic         s_ack = 1'b0;
    logic [1:0]   s_ackch = '0;
    logic         s_clr = 1'b0;
    logic [127:0] s_dout = '0;
    logic [3:0]   s_eout = '0;
    logic [1:0]   s_dsel = '0;

    typedef struct packed {
        int           cyc;
        logic [127:0] din;
        logic [3:0]   pend;
        logic [3:0]   ovr;
        logic [3:0]   oval;
        logic [127:0] oreg;
    } exp_t;
    exp_t sb[$];

    // reference model state
    logic [127:0] m_din;
    logic [3:0]   m_pend, m_ovr, m_oval, m_eo_prev;
    logic [127:0] m_oreg;
    bit           m_hist[$];
    bit           m_level;
    int           m_run;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc_cnt, act, exp);
        end
    endtask

    task automatic model_reset();
        m_din = '0; m_pend = '0; m_ovr = '0; m_oval = '0; m_eo_prev = '0; m_oreg = '0;
        m_hist = '{0, 0, 0};
        m_level = 1'b0;
        m_run = 0;
    endtask

    // One clock of the reference behaviour, from this cycle's inputs to next cycle's outputs.
    task automatic model_step();
        bit   bs;
        bit   evt;
        bit   ackc, pressc;
        exp_t e;
        evt = 1'b0;
        // the button is seen two cycles late; a level change is accepted once
        // DEB_CNT+1 consecutive late samples disagree with the current level
        m_hist.push_front(btn_enter);
        bs = m_hist[2];
        m_hist.delete(3);
        if (bs != m_level) begin
            m_run++;
            if (m_run == DEB_CNT + 1) begin
                evt = !m_level;
                m_level = bs;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (ovr_clr) m_ovr = '0;
        for (int c = 0; c < 4; c++) begin
            ackc   = in_ack && (int'(in_ack_ch) == c);
            pressc = evt && (int'(ch_sel) == c);
            if (pressc) begin
                if (m_pend[c] && !ackc) m_ovr[c] = 1'b1;
                else begin
                    m_din[c*32 +: 32] = sw_in;
                    m_pend[c] = 1'b1;
                end
            end else if (ackc) begin
                m_pend[c] = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (enter_out[k] && !m_eo_prev[k]) begin
                m_oreg[k*32 +: 32] = dev_out[k*32 +: 32];
                m_oval[k] = 1'b1;
            end
        end
        m_eo_prev = enter_out;
        e.cyc = cyc_cnt + 1;
        e.din = m_din; e.pend = m_pend; e.ovr = m_ovr; e.oval = m_oval; e.oreg = m_oreg;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        btn_enter = s_btn; sw_in = s_sw; ch_sel = s_ch; in_ack = s_ack;
        in_ack_ch = s_ackch; ovr_clr = s_clr; dev_out = s_dout; enter_out = s_eout;
        disp_sel = s_dsel;
        model_step();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic zero_stim();
        s_btn = 0; s_sw = '0; s_ch = '0; s_ack = 0; s_ackch = '0; s_clr = 0;
        s_dout = '0; s_eout = '0;
        btn_enter = 0; sw_in = '0; ch_sel = '0; in_ack = 0; in_ack_ch = '0;
        ovr_clr = 0; dev_out = '0; enter_out = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dev_in"}, dev_in, '0);
        chk({tag, "_enter_in"}, {124'b0, enter_in}, '0);
        chk({tag, "_overrun"}, {124'b0, overrun}, '0);
        chk({tag, "_out_valid"}, {124'b0, out_valid}, '0);
        chk({tag, "_disp_data"}, {96'b0, disp_data}, '0);
    endtask

    // Reset lands mid-cycle, so the zero check proves it does not wait for a clock edge.
    task automatic mid_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        zero_stim();
        #1;
        check_all_zero("async_reset");
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic press(input logic [1:0] ch, input logic [31:0] sw, input int hi, input int ack_at);
        s_ch = ch; s_sw = sw; s_btn = 1'b1;
        for (int i = 0; i < hi; i++) begin
            s_ack = (i == ack_at);
            s_ackch = ch;
            cyc();
        end
        s_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
                n_tests++; n_fail++;
                $display("FAIL sb_stale: entry for cyc %0d not checked, now %0d", sb[0].cyc, cyc_cnt);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
                exp_t e;
                e = sb.pop_front();
                chk("dev_in", dev_in, e.din);
                chk("enter_in", {124'b0, enter_in}, {124'b0, e.pend});
                chk("overrun", {124'b0, overrun}, {124'b0, e.ovr});
                chk("out_valid", {124'b0, out_valid}, {124'b0, e.oval});
                chk("disp_data", {96'b0, disp_data}, {96'b0, e.oreg[disp_sel*32 +: 32]});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        zero_stim();
        #12;
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // short glitch: no event
        press(2'd0, 32'hAAAA_0000, 3, -1);
        s_btn = 0; cycles(10);
        chk("glitch_enter_in", {124'b0, enter_in}, 128'h0);

        // clean press on channel 2
        press(2'd2, 32'hDEADBEEF, 10, -1);
        chk("press_ch2_enter", {124'b0, enter_in}, 128'h4);
        chk("press_ch2_data", {96'b0, dev_in[95:64]}, {96'b0, 32'hDEADBEEF});
        s_btn = 0; cycles(10);

        // second press while pending -> overrun, data kept
        press(2'd2, 32'h1, 10, -1);
        chk("ovr_data_kept", {96'b0, dev_in[95:64]}, {96'b0, 32'hDEADBEEF});
        chk("ovr_flag", {124'b0, overrun}, 128'h4);
        s_btn = 0; s_clr = 1; cyc(); s_clr = 0; cyc();
        chk("ovr_cleared", {124'b0, overrun}, 128'h0);
        cycles(8);

        // fill channel 1, then press again with an ack in the event cycle
        press(2'd1, 32'h11, 10, -1);
        s_btn = 0; cycles(10);
        press(2'd1, 32'h55, 10, DEB_CNT + 2);
        chk("collide_enter1", {127'b0, enter_in[1]}, 128'h1);
        chk("collide_data1", {96'b0, dev_in[63:32]}, {96'b0, 32'h55});
        chk("collide_ovr1", {127'b0, overrun[1]}, 128'h0);
        s_btn = 0; cycles(10);

        // output latch, held strobe latches once
        s_dsel = 2'd0;
        s_dout = {96'h0, 32'h12345678}; s_eout = 4'b0001; cycles(5);
        s_dout = '0; cycles(3);
        s_eout = 4'b0000; cycles(2);
        chk("latch0_disp", {96'b0, disp_data}, {96'b0, 32'h12345678});
        chk("latch0_valid", {124'b0, out_valid}, 128'h1);

        // two channels latching in one cycle; disp_sel is combinational
        s_dout = {32'hC3C3C3C3, 32'h22222222, 32'hA1A1A1A1, 32'h44444444};
        s_eout = 4'b1010; cyc(); cyc();
        disp_sel = 2'd3; #1;
        chk("multi_disp3", {96'b0, disp_data}, {96'b0, 32'hC3C3C3C3});
        disp_sel = 2'd1; #1;
        chk("multi_disp1", {96'b0, disp_data}, {96'b0, 32'hA1A1A1A1});
        chk("multi_valid", {124'b0, out_valid}, 128'hB);
        s_dsel = 2'd1; s_eout = 4'b0000; cyc();

        // leave channels 0 and 2 pending, then reset in the middle of a cycle
        s_ack = 1; s_ackch = 2'd1; cyc(); s_ack = 0;
        cycles(9);
        press(2'd0, 32'h0F0F0F0F, 10, -1);
        chk("pending_0101", {124'b0, enter_in}, 128'h5);
        mid_reset();

        // randomized traffic
        begin
            int seg;
            seg = 0;
            for (int i = 0; i < 3000; i++) begin
                if (seg == 0) begin
                    s_btn = ~s_btn;
                    seg = $urandom_range(1, 12);
                end
                seg--;
                s_sw    = $urandom;
                s_ch    = 2'($urandom_range(0, 3));
                s_ack   = ($urandom_range(0, 3) == 0);
                s_ackch = 2'($urandom_range(0, 3));
                s_clr   = ($urandom_range(0, 15) == 0);
                s_dout  = {$urandom, $urandom, $urandom, $urandom};
                s_eout  = s_eout ^ (4'($urandom) & 4'($urandom));
                s_dsel  = 2'($urandom_range(0, 3));
                cyc();
            end
        end

        s_ack = 0; s_clr = 0; s_eout = '0;
        cycles(2);
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
